// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues word-aligned reads to instruction memory and holds the returned
// word for the core until it is retired. It also presents the decoded
// control fields and the architectural pc+8 value.
// A sticky fault is raised when the memory leaves a request unacknowledged
// for ACK_TIMEOUT consecutive cycles. Only reset clears the fault.
// Every output is driven from a flop. The flops load values computed from
// the next-state logic, so each output always matches the current state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [31:0] pc_plus_8,
    input  logic        pc_ctrl,
    input  logic [31:0] pc_result,
    output logic        fault
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    // Wait-counter value seen during the final tolerated unacknowledged cycle.
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [7:0]  wait_cnt_r;

    logic [1:0]  state_s;
    logic [31:0] pc_s;
    logic [7:0]  wait_cnt_s;
    logic [31:0] instr_s;

    // Next-state, next-pc, wait-counter and captured-word logic.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        wait_cnt_s = wait_cnt_r;
        instr_s    = instr;
        case (state_r)
            ST_IDLE: begin
                state_s    = ST_FETCH;
                wait_cnt_s = 8'd0;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_s    = imem_rdata;
                    state_s    = ST_HOLD;
                    wait_cnt_s = 8'd0;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s    = ST_FAULT;
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    if (pc_ctrl) begin
                        // Redirect targets are forced to word alignment.
                        pc_s = pc_result & 32'hFFFF_FFFC;
                    end else begin
                        pc_s = pc_r + 32'd4;
                    end
                    state_s    = ST_FETCH;
                    wait_cnt_s = 8'd0;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
            default: begin
                state_s    = ST_IDLE;
                wait_cnt_s = 8'd0;
            end
        endcase
    end

    // Internal state, program counter and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Memory-side outputs: a request is pending only in FETCH.
    // The address register tracks the pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            imem_req  <= (state_s == ST_FETCH);
            imem_addr <= pc_s;
        end
    end

    // Core-side outputs: the held word, its decoded fields and pc+8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            cond        <= 4'd0;
            op          <= 2'd0;
            funct       <= 6'd0;
            rd          <= 4'd0;
            pc_plus_8   <= RESET_PC + 32'd8;
        end else begin
            instr_valid <= (state_s == ST_HOLD);
            instr       <= instr_s;
            cond        <= instr_s[31:28];
            op          <= instr_s[27:26];
            funct       <= instr_s[25:20];
            rd          <= instr_s[15:12];
            pc_plus_8   <= pc_s + 32'd8;
        end
    end

    // Sticky fault flag; it is asserted only while in FAULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_s == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Instance A uses the default parameters. Its outputs are compared every
// cycle against a transaction-level reference model.
// Instance B uses RESET_PC=FFFF_FFFC and ACK_TIMEOUT=4. It covers pc
// wrap-around and the fetch timeout.
module tb_fetch_unit;

    localparam logic [31:0] A_RESET_PC = 32'h0000_0000;
    localparam int          A_TIMEOUT  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A signals
    logic        rst, imem_ack, instr_ready, pc_ctrl;
    logic [31:0] imem_rdata, pc_result;
    logic        imem_req, instr_valid, fault;
    logic [31:0] imem_addr, instr, pc_plus_8;
    logic [3:0]  cond, rd;
    logic [1:0]  op;
    logic [5:0]  funct;

    // Instance B signals
    logic        rst_b, imem_ack_b, instr_ready_b, pc_ctrl_b;
    logic [31:0] imem_rdata_b, pc_result_b;
    logic        imem_req_b, instr_valid_b, fault_b;
    logic [31:0] imem_addr_b, instr_b, pc_plus_8_b;
    logic [3:0]  cond_b, rd_b;
    logic [1:0]  op_b;
    logic [5:0]  funct_b;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .cond(cond), .op(op),
        .funct(funct), .rd(rd), .pc_plus_8(pc_plus_8), .pc_ctrl(pc_ctrl),
        .pc_result(pc_result), .fault(fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ACK_TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b), .instr_valid(instr_valid_b),
        .instr_ready(instr_ready_b), .instr(instr_b), .cond(cond_b), .op(op_b),
        .funct(funct_b), .rd(rd_b), .pc_plus_8(pc_plus_8_b), .pc_ctrl(pc_ctrl_b),
        .pc_result(pc_result_b), .fault(fault_b)
    );

    // Reference model for instance A (phase of the fetch protocol)
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HOLD  = 2;
    localparam int M_FAULT = 3;
    int          m_mode = M_IDLE;
    int          m_wait = 0;
    logic [31:0] m_pc    = A_RESET_PC;
    logic [31:0] m_instr = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied at that edge.
    task automatic model_edge();
        if (rst) begin
            m_mode = M_IDLE; m_pc = A_RESET_PC; m_instr = 32'd0; m_wait = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin m_mode = M_FETCH; m_wait = 0; end
                M_FETCH: begin
                    if (imem_ack) begin
                        m_instr = imem_rdata; m_mode = M_HOLD;
                    end else begin
                        m_wait = m_wait + 1;
                        if (m_wait >= A_TIMEOUT) m_mode = M_FAULT;
                    end
                end
                M_HOLD: begin
                    if (instr_ready) begin
                        m_pc   = pc_ctrl ? (pc_result & 32'hFFFF_FFFC) : (m_pc + 32'd4);
                        m_mode = M_FETCH;
                        m_wait = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("req",       imem_req,    (m_mode == M_FETCH));
        check_eq("addr",      imem_addr,   m_pc);
        check_eq("valid",     instr_valid, (m_mode == M_HOLD));
        check_eq("fault",     fault,       (m_mode == M_FAULT));
        check_eq("instr",     instr,       m_instr);
        check_eq("cond",      cond,        m_instr[31:28]);
        check_eq("op",        op,          m_instr[27:26]);
        check_eq("funct",     funct,       m_instr[25:20]);
        check_eq("rd",        rd,          m_instr[15:12]);
        check_eq("pc_plus_8", pc_plus_8,   m_pc + 32'd8);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick_b();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Main stimulus sequence
    initial begin
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; pc_ctrl = 1'b0;
        imem_rdata = 32'd0; pc_result = 32'd0;
        rst_b = 1'b1; imem_ack_b = 1'b0; instr_ready_b = 1'b0; pc_ctrl_b = 1'b0;
        imem_rdata_b = 32'd0; pc_result_b = 32'd0;

        // Reset state
        @(negedge clk);
        step();
        step();
        check_eq("rst_req", imem_req, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_instr", instr, 32'd0);

        // Ack tied high, sequential retire: addresses 0, 4, 8
        rst = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        check_eq("seq_fetch0_req", imem_req, 32'd1);
        check_eq("seq_fetch0_addr", imem_addr, 32'h0);
        step();
        check_eq("seq_hold0_valid", instr_valid, 32'd1);
        step();
        check_eq("seq_fetch1_addr", imem_addr, 32'h4);
        step();
        step();
        check_eq("seq_fetch2_addr", imem_addr, 32'h8);

        // Ack delayed by 3 cycles: address stable for all 4 request cycles
        imem_ack = 1'b0; instr_ready = 1'b0;
        check_eq("dly_c1_addr", imem_addr, 32'h8);
        for (int c = 2; c <= 4; c++) begin
            step();
            check_eq("dly_req", imem_req, 32'd1);
            check_eq("dly_addr", imem_addr, 32'h8);
        end
        imem_ack = 1'b1; imem_rdata = 32'hE080_2003;
        step();
        imem_ack = 1'b0;
        check_eq("dly_instr", instr, 32'hE080_2003);
        check_eq("dly_cond", cond, 32'hE);
        check_eq("dly_op", op, 32'h0);
        check_eq("dly_funct", funct, 32'h08);
        check_eq("dly_rd", rd, 32'h2);

        // Redirect ignored while not ready, then taken
        pc_ctrl = 1'b1; pc_result = 32'h0000_0103; instr_ready = 1'b0;
        step();
        check_eq("redir_hold_valid", instr_valid, 32'd1);
        check_eq("redir_hold_addr", imem_addr, 32'h8);
        instr_ready = 1'b1;
        step();
        check_eq("redir_addr", imem_addr, 32'h0000_0100);
        pc_ctrl = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            imem_ack    = ($urandom_range(0, 9) < 6);
            imem_rdata  = $urandom;
            instr_ready = $urandom_range(0, 1) == 1;
            pc_ctrl     = ($urandom_range(0, 3) == 0);
            pc_result   = $urandom;
            step();
        end

        // Reset during a 2-cycle-old fetch, then a late ack
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; pc_ctrl = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        check_eq("abort_pre_req", imem_req, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_async_req", imem_req, 32'd0);
        check_eq("abort_async_instr", instr, 32'd0);
        step();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check_eq("late_ack_instr", instr, 32'd0);
        check_eq("late_ack_valid", instr_valid, 32'd0);
        check_eq("late_ack_addr", imem_addr, 32'd0);
        imem_ack = 1'b0;
        step();
        check_eq("late_wait_instr", instr, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0F0F;
        step();
        check_eq("fresh_ack_instr", instr, 32'hA5A5_0F0F);
        rst = 1'b1; imem_ack = 1'b0;

        // Instance B: wrap-around from RESET_PC=FFFF_FFFC
        check_eq("b_rst_addr", imem_addr_b, 32'hFFFF_FFFC);
        check_eq("b_rst_pc8", pc_plus_8_b, 32'h0000_0004);
        rst_b = 1'b0; imem_ack_b = 1'b1; instr_ready_b = 1'b1;
        tick_b();
        check_eq("b_wrap_fetch_addr", imem_addr_b, 32'hFFFF_FFFC);
        check_eq("b_wrap_pc8", pc_plus_8_b, 32'h0000_0004);
        tick_b();
        check_eq("b_wrap_hold_valid", instr_valid_b, 32'd1);
        tick_b();
        check_eq("b_wrap_next_addr", imem_addr_b, 32'h0000_0000);
        check_eq("b_wrap_next_pc8", pc_plus_8_b, 32'h0000_0008);

        // Instance B: timeout after 4 unacknowledged fetch cycles
        imem_ack_b = 1'b0; instr_ready_b = 1'b0; rst_b = 1'b1;
        tick_b();
        rst_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick_b();
            check_eq("b_to_req", imem_req_b, 32'd1);
            check_eq("b_to_nofault", fault_b, 32'd0);
        end
        tick_b();
        check_eq("b_fault", fault_b, 32'd1);
        check_eq("b_fault_req", imem_req_b, 32'd0);
        check_eq("b_fault_valid", instr_valid_b, 32'd0);
        imem_ack_b = 1'b1; instr_ready_b = 1'b1;
        tick_b();
        tick_b();
        check_eq("b_fault_sticky", fault_b, 32'd1);
        check_eq("b_fault_sticky_req", imem_req_b, 32'd0);
        rst_b = 1'b1;
        #1;
        check_eq("b_fault_cleared", fault_b, 32'd0);
        tick_b();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
